// File: rtl/ex_stage_if.sv
// ex_stage_if: decode-to-execute bundle plus the execute-stage results.
// The master side is decode/controller, the slave side is ex_stage.
interface ex_stage_if;
  // Decode / controller side
  logic        stall_i;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;

  // Execute results
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_req_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output stall_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    input  wd_o, wreg_o, wdata_o, stall_req_o, hi_o, lo_o
  );

  modport slave (
    input  stall_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    output wd_o, wreg_o, wdata_o, stall_req_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage. Holds the ID/EX latch, the logic/shift/move
// ALU, the HI/LO registers and a restoring shift-subtract DIV/DIVU engine.
// GPR results are combinational from the latch; division stalls the pipe.
module ex_stage #(
  parameter int unsigned DIV_ITERS = 32
) (
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave bus
);

  localparam int unsigned CW = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(DIV_ITERS - 1);

  // Operation codes from decode
  localparam logic [7:0] OP_AND  = 8'b0010_0100;
  localparam logic [7:0] OP_OR   = 8'b0010_0101;
  localparam logic [7:0] OP_XOR  = 8'b0010_0110;
  localparam logic [7:0] OP_NOR  = 8'b0010_0111;
  localparam logic [7:0] OP_SLL  = 8'b0111_1100;
  localparam logic [7:0] OP_SRL  = 8'b0000_0010;
  localparam logic [7:0] OP_SRA  = 8'b0000_0011;
  localparam logic [7:0] OP_MOVE = 8'b0000_1011;
  localparam logic [7:0] OP_MFHI = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO = 8'b0001_0011;
  localparam logic [7:0] OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU = 8'b0001_1011;

  // Result classes
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_e;

  // ID/EX latch contents
  logic [7:0]  ex_aluop;
  logic [2:0]  ex_alusel;
  logic [31:0] ex_reg1;
  logic [31:0] ex_reg2;
  logic [4:0]  ex_wd;
  logic        ex_wreg;

  // Architectural HI/LO
  logic [31:0] hi;
  logic [31:0] lo;

  // Divider state
  div_state_e  state;
  logic [CW-1:0] cnt;
  logic [31:0] dvd;        // dividend magnitude; quotient bits shift in at the bottom
  logic [31:0] dvs;        // divisor magnitude
  logic [32:0] rem;        // partial remainder
  logic        neg_q;
  logic        neg_r;
  logic        consumed;   // result of the latched division already written

  logic        is_div;
  logic        is_signed;
  logic        div_start;
  logic        stall_req;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [32:0] rem_shift;
  logic        fits;
  logic [32:0] rem_next;
  logic [31:0] quot_final;
  logic [31:0] rem_final;
  logic [31:0] logic_res;
  logic [31:0] shift_res;
  logic [31:0] move_res;
  logic [31:0] wdata;

  // ID/EX pipeline latch: capture when not stalled, clear to a nop on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_aluop  <= '0;
      ex_alusel <= '0;
      ex_reg1   <= '0;
      ex_reg2   <= '0;
      ex_wd     <= '0;
      ex_wreg   <= 1'b0;
    end else if (!bus.stall_i) begin
      ex_aluop  <= bus.aluop_i;
      ex_alusel <= bus.alusel_i;
      ex_reg1   <= bus.reg1_i;
      ex_reg2   <= bus.reg2_i;
      ex_wd     <= bus.wd_i;
      ex_wreg   <= bus.wreg_i;
    end
  end

  // Divider operand conditioning and one restoring shift-subtract step
  always_comb begin
    is_div     = (ex_aluop == OP_DIV) || (ex_aluop == OP_DIVU);
    is_signed  = (ex_aluop == OP_DIV);
    div_start  = is_div && !consumed;
    mag1       = (is_signed && ex_reg1[31]) ? (~ex_reg1 + 32'd1) : ex_reg1;
    mag2       = (is_signed && ex_reg2[31]) ? (~ex_reg2 + 32'd1) : ex_reg2;
    rem_shift  = {rem[31:0], dvd[31]};
    fits       = (rem_shift >= {1'b0, dvs});
    rem_next   = fits ? (rem_shift - {1'b0, dvs}) : rem_shift;
    quot_final = neg_q ? (~dvd + 32'd1) : dvd;
    rem_final  = neg_r ? (~rem[31:0] + 32'd1) : rem[31:0];
    stall_req  = ((state == DIV_IDLE) && div_start) || (state == DIV_RUN);
  end

  // Divider FSM: IDLE captures operands, RUN iterates, DONE hands off to HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DIV_IDLE;
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      consumed <= 1'b0;
    end else begin
      // A latch reload means a new instruction; a held latch after DONE must
      // not restart the same division.
      if (!bus.stall_i) begin
        consumed <= 1'b0;
      end else if (state == DIV_DONE) begin
        consumed <= 1'b1;
      end

      unique case (state)
        DIV_IDLE: begin
          if (div_start) begin
            neg_q <= is_signed && (ex_reg1[31] ^ ex_reg2[31]);
            neg_r <= is_signed && ex_reg1[31];
            dvs   <= mag2;
            rem   <= '0;
            cnt   <= '0;
            if (ex_reg2 == 32'd0) begin
              dvd   <= '0;
              state <= DIV_DONE;
            end else begin
              dvd   <= mag1;
              state <= DIV_RUN;
            end
          end
        end
        DIV_RUN: begin
          rem <= rem_next;
          dvd <= {dvd[30:0], fits};
          if (cnt == LAST_ITER) begin
            state <= DIV_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV_DONE: begin
          state <= DIV_IDLE;
        end
        default: begin
          state <= DIV_IDLE;
        end
      endcase
    end
  end

  // HI/LO update at the edge ending the writing instruction's EX cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == DIV_DONE) begin
      hi <= rem_final;
      lo <= quot_final;
    end else if (ex_aluop == OP_MTHI) begin
      hi <= ex_reg1;
    end else if (ex_aluop == OP_MTLO) begin
      lo <= ex_reg1;
    end
  end

  // Per-class ALU results and final write-data select
  always_comb begin
    logic_res = '0;
    unique case (ex_aluop)
      OP_AND:  logic_res = ex_reg1 & ex_reg2;
      OP_OR:   logic_res = ex_reg1 | ex_reg2;
      OP_XOR:  logic_res = ex_reg1 ^ ex_reg2;
      OP_NOR:  logic_res = ~(ex_reg1 | ex_reg2);
      default: logic_res = '0;
    endcase

    shift_res = '0;
    unique case (ex_aluop)
      OP_SLL:  shift_res = ex_reg2 << ex_reg1[4:0];
      OP_SRL:  shift_res = ex_reg2 >> ex_reg1[4:0];
      OP_SRA:  shift_res = $signed(ex_reg2) >>> ex_reg1[4:0];
      default: shift_res = '0;
    endcase

    move_res = '0;
    unique case (ex_aluop)
      OP_MOVE: move_res = ex_reg1;
      OP_MFHI: move_res = hi;
      OP_MFLO: move_res = lo;
      default: move_res = '0;
    endcase

    wdata = '0;
    unique case (ex_alusel)
      SEL_LOGIC: wdata = logic_res;
      SEL_SHIFT: wdata = shift_res;
      SEL_MOVE:  wdata = move_res;
      default:   wdata = '0;
    endcase
  end

  assign bus.wd_o        = ex_wd;
  assign bus.wreg_o      = ex_wreg && !stall_req;
  assign bus.wdata_o     = wdata;
  assign bus.stall_req_o = stall_req;
  assign bus.hi_o        = hi;
  assign bus.lo_o        = lo;

endmodule
